// File: rtl/gpr_mp.sv
// Multi-ported general-purpose register file with a destination scoreboard.
// x0 is hardwired to zero; the stack-pointer register resets to SP_RESET.
module gpr_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter bit          BYPASS   = 1'b1,
   parameter int unsigned SP_IDX   = 2,
   parameter logic [XLEN-1:0] SP_RESET = 'h8000_0000,
   localparam int unsigned IW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NRD*IW-1:0]   rd_idx,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*IW-1:0]   wr_idx,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_valid,
   input  logic [IW-1:0]       alloc_idx,
   output logic                alloc_ready,
   output logic [IW:0]         busy_cnt,
   output logic                wr_ready
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d, wr_hit;
   logic [IW:0]     busy_cnt_q, busy_cnt_d;

   // Ascending port order makes the highest-numbered write port win.
   always_comb begin
      regs_d = regs_q;
      wr_hit = '0;
      if (rstn) begin
         for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
               wr_hit[wr_idx[w*IW +: IW]] = 1'b1;
               regs_d[wr_idx[w*IW +: IW]] = wr_data[w*XLEN +: XLEN];
            end
         end
      end
      regs_d[0] = '0;
      wr_hit[0] = 1'b0;
   end

   assign alloc_ready = rstn && (!busy_q[alloc_idx] || wr_hit[alloc_idx]);
   assign wr_ready    = rstn;
   assign busy_cnt    = busy_cnt_q;

   // Set wins over clear when an alloc and a write hit the same index.
   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (alloc_valid && alloc_ready) begin
         busy_d[alloc_idx] = 1'b1;
      end
      busy_d[0] = 1'b0;
      busy_cnt_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         busy_cnt_d = busy_cnt_d + {{IW{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Forwarding reads the next-state array, which already holds the winning write.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < NRD; p++) begin
         if (BYPASS) begin
            rd_data[p*XLEN +: XLEN] = regs_d[rd_idx[p*IW +: IW]];
            rd_busy[p] = busy_q[rd_idx[p*IW +: IW]] & ~wr_hit[rd_idx[p*IW +: IW]];
         end else begin
            rd_data[p*XLEN +: XLEN] = regs_q[rd_idx[p*IW +: IW]];
            rd_busy[p] = busy_q[rd_idx[p*IW +: IW]];
         end
      end
   end

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: forwarding and non-forwarding instances share stimulus and
// are checked each cycle against an array/scoreboard model of the register file.
module tb_gpr_mp;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int IW   = 5;
   localparam logic [XLEN-1:0] SP_VAL = 32'h8000_0000;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic [NRD*IW-1:0]   rd_idx;
   logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]      rd_busy_b, rd_busy_n;
   logic [NWR-1:0]      wr_en;
   logic [NWR*IW-1:0]   wr_idx;
   logic [NWR*XLEN-1:0] wr_data;
   logic                alloc_valid;
   logic [IW-1:0]       alloc_idx;
   logic                alloc_ready_b, alloc_ready_n;
   logic [IW:0]         busy_cnt_b, busy_cnt_n;
   logic                wr_ready_b, wr_ready_n;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1),
            .SP_IDX(2), .SP_RESET(SP_VAL)) u_byp (
      .clk(clk), .rstn(rstn), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_valid(alloc_valid),
      .alloc_idx(alloc_idx), .alloc_ready(alloc_ready_b), .busy_cnt(busy_cnt_b),
      .wr_ready(wr_ready_b));

   gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0),
            .SP_IDX(2), .SP_RESET(SP_VAL)) u_nob (
      .clk(clk), .rstn(rstn), .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_valid(alloc_valid),
      .alloc_idx(alloc_idx), .alloc_ready(alloc_ready_n), .busy_cnt(busy_cnt_n),
      .wr_ready(wr_ready_n));

   // ---------------- model: register array + busy flags ----------------
   logic [XLEN-1:0] m_reg [NREG];
   bit              m_busy [NREG];

   function automatic int widx(int w);
      return int'(wr_idx[w*IW +: IW]);
   endfunction

   function automatic bit written(int i);
      if (!rstn || i == 0) return 1'b0;
      for (int w = 0; w < NWR; w++)
         if (wr_en[w] && widx(w) == i) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] post_val(int i);
      logic [XLEN-1:0] v;
      v = m_reg[i];
      if (rstn && i != 0)
         for (int w = 0; w < NWR; w++)
            if (wr_en[w] && widx(w) == i) v = wr_data[w*XLEN +: XLEN];
      return v;
   endfunction

   function automatic bit exp_alloc_ready();
      int a;
      a = int'(alloc_idx);
      if (!rstn) return 1'b0;
      return (a == 0) || !m_busy[a] || written(a);
   endfunction

   function automatic int exp_cnt();
      int c;
      c = 0;
      for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) begin
            m_reg[i]  <= (i == 2) ? SP_VAL : '0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            m_reg[i]  <= post_val(i);
            m_busy[i] <= (m_busy[i] && !written(i)) ||
                         (alloc_valid && exp_alloc_ready() && i != 0 && int'(alloc_idx) == i);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int p = 0; p < NRD; p++) begin
         int ix;
         ix = int'(rd_idx[p*IW +: IW]);
         check("rd_data_byp", 64'(rd_data_b[p*XLEN +: XLEN]), 64'(post_val(ix)));
         check("rd_data_nob", 64'(rd_data_n[p*XLEN +: XLEN]), 64'(m_reg[ix]));
         check("rd_busy_byp", 64'(rd_busy_b[p]), 64'(m_busy[ix] && !written(ix)));
         check("rd_busy_nob", 64'(rd_busy_n[p]), 64'(m_busy[ix]));
      end
      check("alloc_ready_byp", 64'(alloc_ready_b), 64'(exp_alloc_ready()));
      check("alloc_ready_nob", 64'(alloc_ready_n), 64'(exp_alloc_ready()));
      check("busy_cnt_byp", 64'(busy_cnt_b), 64'(exp_cnt()));
      check("busy_cnt_nob", 64'(busy_cnt_n), 64'(exp_cnt()));
      check("wr_ready_byp", 64'(wr_ready_b), 64'(rstn));
      check("wr_ready_nob", 64'(wr_ready_n), 64'(rstn));
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      wr_en = '0; wr_idx = '0; wr_data = '0;
      alloc_valid = 1'b0; alloc_idx = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int w, input int idx, input logic [XLEN-1:0] d);
      wr_en[w] = 1'b1;
      wr_idx[w*IW +: IW] = IW'(idx);
      wr_data[w*XLEN +: XLEN] = d;
   endtask

   task automatic rd(input int p, input int idx);
      rd_idx[p*IW +: IW] = IW'(idx);
   endtask

   task automatic alloc(input int idx);
      alloc_valid = 1'b1;
      alloc_idx = IW'(idx);
   endtask

   function automatic logic [XLEN-1:0] rdb(input int p);
      return rd_data_b[p*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] rdn(input int p);
      return rd_data_n[p*XLEN +: XLEN];
   endfunction

   // ---------------- directed vectors ----------------
   initial begin
      idle();
      rd_idx = '0;
      step();
      // activity while held in reset is ignored
      wr(0, 5, 32'd77); alloc(5); rd(0, 2); rd(1, 5); #2;
      check("rst_sp", 64'(rdb(0)), 64'h8000_0000);
      check("rst_r5", 64'(rdb(1)), 64'h0);
      check("rst_alloc_ready", 64'(alloc_ready_b), 64'h0);
      check("rst_wr_ready", 64'(wr_ready_b), 64'h0);
      step(); step();
      rstn = 1'b1;
      idle(); rd(0, 2); rd(1, 5); #2;
      check("post_rst_sp", 64'(rdb(0)), 64'h8000_0000);
      check("post_rst_r5", 64'(rdn(1)), 64'h0);
      check("post_rst_cnt", 64'(busy_cnt_b), 64'h0);
      check("post_rst_alloc_ready", 64'(alloc_ready_b), 64'h1);
      step();

      idle(); wr(0, 0, 32'hDEAD_BEEF); rd(0, 0); #2;
      check("x0_bypass", 64'(rdb(0)), 64'h0);
      step();
      idle(); alloc(0); rd(0, 0); #2;
      check("x0_read", 64'(rdn(0)), 64'h0);
      check("x0_alloc_ready", 64'(alloc_ready_b), 64'h1);
      step();
      idle(); #2;
      check("x0_cnt", 64'(busy_cnt_b), 64'h0);
      step();

      idle(); wr(0, 7, 32'h1234); rd(1, 7); #2;
      check("byp_fwd", 64'(rdb(1)), 64'h1234);
      check("nob_old", 64'(rdn(1)), 64'h0);
      step();
      idle(); rd(1, 7); #2;
      check("nob_new", 64'(rdn(1)), 64'h1234);
      step();

      idle(); wr(0, 9, 32'hAAAA); wr(1, 9, 32'h5555); rd(0, 9); #2;
      check("conflict_fwd", 64'(rdb(0)), 64'h5555);
      step();
      idle(); rd(0, 9); #2;
      check("conflict_store", 64'(rdn(0)), 64'h5555);
      step();

      idle(); alloc(3); rd(0, 3); #2;
      check("sb_alloc_ready", 64'(alloc_ready_b), 64'h1);
      step();
      idle(); alloc(3); rd(0, 3); #2;
      check("sb_busy", 64'(rd_busy_b[0]), 64'h1);
      check("sb_cnt1", 64'(busy_cnt_b), 64'h1);
      check("sb_waw_stall", 64'(alloc_ready_b), 64'h0);
      step();
      idle(); wr(0, 3, 32'h3); alloc(3); rd(0, 3); #2;
      check("sb_cnt_stalled", 64'(busy_cnt_b), 64'h1);
      check("sb_wr_alloc_ready", 64'(alloc_ready_b), 64'h1);
      check("sb_byp_busy", 64'(rd_busy_b[0]), 64'h0);
      check("sb_nob_busy", 64'(rd_busy_n[0]), 64'h1);
      step();
      idle(); wr(1, 3, 32'h33); rd(0, 3); #2;
      check("sb_set_wins", 64'(rd_busy_n[0]), 64'h1);
      check("sb_cnt_kept", 64'(busy_cnt_b), 64'h1);
      step();
      idle(); rd(0, 3); #2;
      check("sb_cleared", 64'(rd_busy_n[0]), 64'h0);
      check("sb_cnt0", 64'(busy_cnt_b), 64'h0);
      check("sb_data", 64'(rdn(0)), 64'h33);
      step();

      idle(); alloc(10); step();
      idle(); alloc(11); step();
      idle(); wr(0, 10, 32'h10); wr(1, 11, 32'h11); alloc(12); #2;
      check("cnt_before", 64'(busy_cnt_b), 64'h2);
      step();
      idle(); wr(0, 12, 32'h12); #2;
      check("cnt_plus1_minus2", 64'(busy_cnt_b), 64'h1);
      step();
      idle(); wr(0, 2, 32'h55); step();
      idle(); rd(0, 2); #2;
      check("sp_written", 64'(rdn(0)), 64'h55);
      check("cnt_empty", 64'(busy_cnt_n), 64'h0);
      step();

      idle(); alloc(4); step();
      idle(); alloc(6); step();
      idle(); alloc(8); step();
      idle(); rd(0, 4); rd(1, 6); #2;
      check("mid_cnt3", 64'(busy_cnt_b), 64'h3);
      step();
      rstn = 1'b0; #2;
      check("mid_rst_cnt", 64'(busy_cnt_b), 64'h0);
      check("mid_rst_busy", 64'(rd_busy_n), 64'h0);
      rd(0, 2); #1;
      check("mid_rst_sp", 64'(rdn(0)), 64'h8000_0000);
      step();
      rstn = 1'b1;
      idle(); alloc(4); rd(0, 4); #2;
      check("first_edge_ready", 64'(alloc_ready_b), 64'h1);
      step();
      idle(); rd(0, 4); #2;
      check("first_edge_busy", 64'(rd_busy_n[0]), 64'h1);
      check("first_edge_cnt", 64'(busy_cnt_b), 64'h1);
      step();

      // mixed traffic, judged by the per-cycle compare against the model
      for (int c = 0; c < 400; c++) begin
         idle();
         for (int w = 0; w < NWR; w++)
            if ($urandom_range(0, 2) == 0) wr(w, int'($urandom_range(0, 15)), XLEN'($urandom));
         if ($urandom_range(0, 1) == 0) alloc(int'($urandom_range(0, 15)));
         rd(0, int'($urandom_range(0, 15)));
         rd(1, int'($urandom_range(0, 15)));
         if (c % 97 == 50) rstn = 1'b0;
         else rstn = 1'b1;
         step();
      end
      rstn = 1'b1;
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
